mat_vec_scheduler: RTL and testbench

Sequencer that computes a matrix-vector product by time-sharing one combinational `inner_product` datapath across the matrix rows. It latches the vector at start and fetches one row per step over a request/valid handshake. It drives the shared datapath operands, registers each dot-product result and emits it over a valid/ready stream tagged with its row index. It sits between the matrix row store and the `inner_product` instance in the matrix-multiply-vector top level.

---
 rtl/mat_vec_scheduler.sv | 127 ++++++++++++
 tb/tb_mat_vec_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mat_vec_scheduler.sv
// rtl/mat_vec_scheduler.sv - row-serial matrix-vector product sequencer around a shared inner_product datapath
module mat_vec_scheduler #(
    parameter int  data_width = 2,
    parameter int  num_elems  = 5,
    parameter int  num_rows   = 4,
    localparam int acc_width  = 2*data_width + $clog2(num_elems+1),
    localparam int idx_width  = (num_rows > 1) ? $clog2(num_rows) : 1,
    localparam int vec_width  = num_elems*data_width
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [vec_width-1:0] vec_in,
    output logic                 row_req,
    output logic [idx_width-1:0] row_addr,
    input  logic                 row_valid,
    input  logic [vec_width-1:0] row_data,
    output logic [vec_width-1:0] ip_a,
    output logic [vec_width-1:0] ip_b,
    input  logic [acc_width-1:0] ip_result,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [acc_width-1:0] res_data,
    output logic [idx_width-1:0] res_index,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_COMPUTE,
        ST_EMIT,
        ST_DONE
    } state_t;

    localparam logic [idx_width-1:0] last_row = idx_width'(num_rows - 1);

    state_t                 state_q, state_d;
    logic [idx_width-1:0]   cnt_q, cnt_d;
    logic [vec_width-1:0]   ip_a_q, ip_a_d;
    logic [vec_width-1:0]   ip_b_q, ip_b_d;
    logic [acc_width-1:0]   res_data_q, res_data_d;
    logic [idx_width-1:0]   res_index_q, res_index_d;

    // State and datapath registers; reset clears all progress immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ip_a_q      <= '0;
            ip_b_q      <= '0;
            res_data_q  <= '0;
            res_index_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ip_a_q      <= ip_a_d;
            ip_b_q      <= ip_b_d;
            res_data_q  <= res_data_d;
            res_index_q <= res_index_d;
        end
    end

    // Next-state logic: abort outranks everything once a product is running.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ip_a_d      = ip_a_q;
        ip_b_d      = ip_b_q;
        res_data_d  = res_data_q;
        res_index_d = res_index_q;
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ip_b_d  = vec_in;
                        cnt_d   = '0;
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (row_valid) begin
                        ip_a_d  = row_data;
                        state_d = ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    // Operands have been stable for a full cycle; take the dot product.
                    res_data_d  = ip_result;
                    res_index_d = cnt_q;
                    state_d     = ST_EMIT;
                end
                ST_EMIT: begin
                    if (res_ready) begin
                        if (cnt_q == last_row) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign row_req   = (state_q == ST_FETCH);
    assign res_valid = (state_q == ST_EMIT);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign row_addr  = cnt_q;
    assign ip_a      = ip_a_q;
    assign ip_b      = ip_b_q;
    assign res_data  = res_data_q;
    assign res_index = res_index_q;

endmodule

// File: tb/tb_mat_vec_scheduler.sv
// tb/tb_mat_vec_scheduler.sv - directed self-checking bench for mat_vec_scheduler
module tb_mat_vec_scheduler;

    localparam int DW = 2;
    localparam int NE = 5;
    localparam int NR = 4;
    localparam int AW = 2*DW + $clog2(NE+1);
    localparam int IW = 2;
    localparam int VW = NE*DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [VW-1:0] vec_in = '0;
    logic          row_req;
    logic [IW-1:0] row_addr;
    logic          row_valid = 1'b0;
    logic [VW-1:0] row_data;
    logic [VW-1:0] ip_a;
    logic [VW-1:0] ip_b;
    logic [AW-1:0] ip_result;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [AW-1:0] res_data;
    logic [IW-1:0] res_index;
    logic          busy;
    logic          done;

    logic [VW-1:0] mat [NR];

    int total = 0;
    int bad   = 0;

    // scenario knobs
    int rv_row, rv_delay, rr_row, rr_delay, abort_row, start_again_k;
    // scenario observations
    int hs_n, done_k, done_n, req1_n, unstable_n, ipb_bad, aborted_k;
    logic busy_after, ab_rv, ab_rq, ab_busy, addr0_req;
    logic [IW-1:0] addr0;
    logic [AW-1:0] hs_data [8];
    logic [IW-1:0] hs_idx  [8];
    int            hs_k    [8];

    always #5 clk = ~clk;

    mat_vec_scheduler #(.data_width(DW), .num_elems(NE), .num_rows(NR)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec_in(vec_in),
        .row_req(row_req), .row_addr(row_addr), .row_valid(row_valid), .row_data(row_data),
        .ip_a(ip_a), .ip_b(ip_b), .ip_result(ip_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_index(res_index),
        .busy(busy), .done(done)
    );

    assign row_data = mat[row_addr];

    always_comb begin
        ip_result = '0;
        for (int i = 0; i < NE; i++)
            ip_result += AW'(ip_a[i*DW +: DW]) * AW'(ip_b[i*DW +: DW]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_knobs_default();
        rv_row = -1; rv_delay = 0; rr_row = -1; rr_delay = 0;
        abort_row = -1; start_again_k = 0;
    endtask

    // Cycle k = k-th negedge after the edge that samples start.
    task automatic run_scn();
        logic held;
        logic [AW-1:0] held_d;
        logic [IW-1:0] held_i;
        int rv_hold, rr_hold;
        hs_n = 0; done_k = 0; done_n = 0; req1_n = 0; unstable_n = 0; ipb_bad = 0;
        aborted_k = 0; busy_after = 1'bx; ab_rv = 1'bx; ab_rq = 1'bx; ab_busy = 1'bx;
        addr0 = 'x; addr0_req = 1'b0;
        held = 1'b0; held_d = '0; held_i = '0; rv_hold = 0; rr_hold = 0;
        @(negedge clk);
        start = 1'b1; row_valid = 1'b1; res_ready = 1'b1; abort = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin addr0 = row_addr; addr0_req = row_req; end
            if (done) begin done_n++; if (done_k == 0) done_k = k; end
            if (done_k != 0 && k == done_k + 1) busy_after = busy;
            if (row_req && row_addr == 2'd1) req1_n++;
            if (res_valid) begin
                if (held && (res_data != held_d || res_index != held_i)) unstable_n++;
                held = 1'b1; held_d = res_data; held_i = res_index;
            end else held = 1'b0;
            if (aborted_k != 0 && k == aborted_k + 1) begin
                ab_rv = res_valid; ab_rq = row_req; ab_busy = busy;
            end
            start = (k == start_again_k);
            row_valid = !(row_req && row_addr == rv_row && rv_hold < rv_delay);
            if (!row_valid) rv_hold++;
            res_ready = !(res_valid && res_index == rr_row && rr_hold < rr_delay);
            if (!res_ready) rr_hold++;
            abort = (aborted_k == 0 && res_valid && res_index == abort_row);
            if (abort) begin aborted_k = k; res_ready = 1'b0; end
            if (res_valid && res_ready && hs_n < 8) begin
                hs_data[hs_n] = res_data; hs_idx[hs_n] = res_index; hs_k[hs_n] = k;
                if (ip_b != vec_in) ipb_bad++;
                hs_n++;
            end
            if (done_k != 0 && k >= done_k + 1) break;
            if (aborted_k != 0 && k >= aborted_k + 3) break;
        end
        start = 1'b0; abort = 1'b0;
        check("scn_terminated", 32'(done_k != 0 || aborted_k != 0), 32'd1);
    endtask

    initial begin
        set_knobs_default();
        for (int r = 0; r < NR; r++) mat[r] = {NE{2'd3}};
        vec_in = {NE{2'd3}};
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_row_req", 32'(row_req), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_ip_b", 32'(ip_b), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // all-3 matrix and vector, tied handshakes, start pulse while busy
        start_again_k = 5;
        run_scn();
        check("t1_hs_n", 32'(hs_n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_data%0d", i), 32'(hs_data[i]), 32'd45);
            check($sformatf("t1_idx%0d", i), 32'(hs_idx[i]), 32'(i));
            check($sformatf("t1_slot%0d", i), 32'(hs_k[i]), 32'(3 + 3*i));
        end
        check("t1_done_k", 32'(done_k), 32'd13);
        check("t1_done_n", 32'(done_n), 32'd1);
        check("t1_busy_after", 32'(busy_after), 32'd0);
        check("t1_first_addr", 32'(addr0), 32'd0);
        check("t1_first_req", 32'(addr0_req), 32'd1);

        // vector all 1, row r elements = r
        set_knobs_default();
        for (int r = 0; r < NR; r++) mat[r] = {NE{2'(r)}};
        vec_in = {NE{2'd1}};
        run_scn();
        check("t2_hs_n", 32'(hs_n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_data%0d", i), 32'(hs_data[i]), 32'(5*i));
            check($sformatf("t2_idx%0d", i), 32'(hs_idx[i]), 32'(i));
        end
        check("t2_ipb_stable", 32'(ipb_bad), 32'd0);
        check("t2_done_k", 32'(done_k), 32'd13);

        // back-pressure: row 1 valid delayed 4, row 2 ready low 2
        set_knobs_default();
        rv_row = 1; rv_delay = 4; rr_row = 2; rr_delay = 2;
        run_scn();
        check("t3_req1_cycles", 32'(req1_n), 32'd5);
        check("t3_unstable", 32'(unstable_n), 32'd0);
        check("t3_hs_n", 32'(hs_n), 32'd4);
        check("t3_slot1", 32'(hs_k[1]), 32'd10);
        check("t3_slot2", 32'(hs_k[2]), 32'd15);
        check("t3_data2", 32'(hs_data[2]), 32'd10);
        check("t3_done_k", 32'(done_k), 32'd19);

        // abort in EMIT of row 2
        set_knobs_default();
        abort_row = 2;
        run_scn();
        check("t4_abort_k", 32'(aborted_k), 32'd9);
        check("t4_res_valid", 32'(ab_rv), 32'd0);
        check("t4_row_req", 32'(ab_rq), 32'd0);
        check("t4_busy", 32'(ab_busy), 32'd0);
        check("t4_done_n", 32'(done_n), 32'd0);
        check("t4_hs_n", 32'(hs_n), 32'd2);
        check("t4_ip_b_kept", 32'(ip_b), 32'({NE{2'd1}}));
        set_knobs_default();
        run_scn();
        check("t4_restart_addr", 32'(addr0), 32'd0);
        check("t4_restart_req", 32'(addr0_req), 32'd1);
        check("t4_restart_done", 32'(done_k), 32'd13);
        check("t4_restart_data3", 32'(hs_data[3]), 32'd15);

        // reset during FETCH
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_in_fetch", 32'(row_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_row_req", 32'(row_req), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_res_data", 32'(res_data), 32'd0);
        check("t5_res_index", 32'(res_index), 32'd0);
        check("t5_ip_b", 32'(ip_b), 32'd0);
        check("t5_ip_a", 32'(ip_a), 32'd0);
        check("t5_row_addr", 32'(row_addr), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_res_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_idle_busy", 32'(busy), 32'd0);
        check("t5_idle_req", 32'(row_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
